// File: rtl/gray_tracker.sv
// Gray-code stream tracker: decodes each accepted sample, classifies it against the previous one, counts laps and latches faults.
// Latency 1 cycle from the Valid posedge; no backpressure, a sample is taken on every cycle Valid is high.
module gray_tracker #(
    parameter int WIDTH = 3,
    parameter int LAP_W = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] GrayIn,
    input  logic             Valid,
    input  logic             Clear,
    output logic [WIDTH-1:0] BinOut,
    output logic             Step,
    output logic             Wrap,
    output logic [LAP_W-1:0] LapCount,
    output logic             Locked,
    output logic             Fault,
    output logic [1:0]       ErrCode
);

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_REV  = 2'b01;
    localparam logic [1:0] ERR_JUMP = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic [1:0]       err_q, err_d;

    logic [WIDTH-1:0] bin_n;
    logic [WIDTH-1:0] prev_plus;
    logic [WIDTH-1:0] prev_minus;

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        bin_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_n[i] = ^(GrayIn >> i);
        end
    end

    assign prev_plus  = bin_q + WIDTH'(1);
    assign prev_minus = bin_q - WIDTH'(1);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        lap_d   = lap_q;
        err_d   = err_q;

        if (Clear) begin
            state_d = S_SYNC;
            lap_d   = '0;
            err_d   = ERR_NONE;
        end else if (Valid) begin
            case (state_q)
                S_SYNC: begin
                    bin_d   = bin_n;
                    state_d = S_TRACK;
                end
                S_TRACK: begin
                    if (bin_n == bin_q) begin
                        state_d = S_TRACK;
                    end else if (bin_n == prev_plus) begin
                        bin_d  = bin_n;
                        step_d = 1'b1;
                        if (bin_q == '1) begin
                            wrap_d = 1'b1;
                            if (lap_q != '1) begin
                                lap_d = lap_q + LAP_W'(1);
                            end
                        end
                    end else if (bin_n == prev_minus) begin
                        bin_d   = bin_n;
                        err_d   = ERR_REV;
                        state_d = S_FAULT;
                    end else begin
                        bin_d   = bin_n;
                        err_d   = ERR_JUMP;
                        state_d = S_FAULT;
                    end
                end
                S_FAULT: begin
                    // Keep following the stream so software sees where it is; cause stays frozen.
                    bin_d = bin_n;
                end
                default: begin
                    state_d = S_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_SYNC;
            bin_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            lap_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            lap_q   <= lap_d;
            err_q   <= err_d;
        end
    end

    assign BinOut   = bin_q;
    assign Step     = step_q;
    assign Wrap     = wrap_q;
    assign LapCount = lap_q;
    assign Locked   = (state_q == S_TRACK);
    assign Fault    = (state_q == S_FAULT);
    assign ErrCode  = err_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Bench for gray_tracker: an 8-bit-lap instance and a 2-bit-lap instance share one stimulus stream.
module tb_gray_tracker;

    logic       clk = 1'b0;
    logic       rst_n, clr, vld;
    logic [2:0] gin;

    logic [2:0] a_bin, b_bin;
    logic       a_step, a_wrap, a_lock, a_fault;
    logic       b_step, b_wrap, b_lock, b_fault;
    logic [7:0] a_lap;
    logic [1:0] b_lap;
    logic [1:0] a_err, b_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: 0 sync, 1 track, 2 fault; lap count kept unbounded.
    int m_st, m_bin, m_lap, m_err, m_step, m_wrap;

    typedef struct {
        bit         r, c, v;
        logic [2:0] g;
        int         bin, step, wrap, lap, lk, ft, err;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    gray_tracker #(.WIDTH(3), .LAP_W(8)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .GrayIn(gin), .Valid(vld), .Clear(clr),
        .BinOut(a_bin), .Step(a_step), .Wrap(a_wrap), .LapCount(a_lap),
        .Locked(a_lock), .Fault(a_fault), .ErrCode(a_err)
    );

    gray_tracker #(.WIDTH(3), .LAP_W(2)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .GrayIn(gin), .Valid(vld), .Clear(clr),
        .BinOut(b_bin), .Step(b_step), .Wrap(b_wrap), .LapCount(b_lap),
        .Locked(b_lock), .Fault(b_fault), .ErrCode(b_err)
    );

    function automatic logic [2:0] gray(int b);
        return 3'((b % 8) ^ ((b % 8) >> 1));
    endfunction

    function automatic int g2b(logic [2:0] g);
        for (int b = 0; b < 8; b++) begin
            if (gray(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic model(bit r, bit c, bit v, int b);
        int d;
        m_step = 0;
        m_wrap = 0;
        d = (b - m_bin + 8) % 8;
        if (!r) begin
            m_st = 0; m_bin = 0; m_lap = 0; m_err = 0;
        end else if (c) begin
            m_st = 0; m_lap = 0; m_err = 0;
        end else if (v) begin
            if (m_st == 0) begin
                m_bin = b; m_st = 1;
            end else if (m_st == 2) begin
                m_bin = b;
            end else if (d == 1) begin
                m_bin = b; m_step = 1;
                if (b == 0) begin
                    m_wrap = 1; m_lap++;
                end
            end else if (d == 7) begin
                m_bin = b; m_err = 1; m_st = 2;
            end else if (d != 0) begin
                m_bin = b; m_err = 2; m_st = 2;
            end
        end
    endtask

    task automatic cyc(bit r, bit c, bit v, logic [2:0] g);
        rst_n = r; clr = c; vld = v; gin = g;
        @(posedge clk);
        model(r, c, v, g2b(g));
        @(negedge clk);
    endtask

    task automatic chk(string tag, string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", tag, nm, act, exp, $time);
        end
    endtask

    task automatic check_exp(string tag, int bin, int step, int wrap, int lap, int lk, int ft, int err);
        int pk;
        pk = (bin << 6) | (step << 5) | (wrap << 4) | (lk << 3) | (ft << 2) | err;
        chk(tag, "bin",   int'(a_bin),   bin);
        chk(tag, "step",  int'(a_step),  step);
        chk(tag, "wrap",  int'(a_wrap),  wrap);
        chk(tag, "lap",   int'(a_lap),   (lap > 255) ? 255 : lap);
        chk(tag, "lap2",  int'(b_lap),   (lap > 3) ? 3 : lap);
        chk(tag, "lock",  int'(a_lock),  lk);
        chk(tag, "fault", int'(a_fault), ft);
        chk(tag, "err",   int'(a_err),   err);
        chk(tag, "dut2",  int'({b_bin, b_step, b_wrap, b_lock, b_fault, b_err}), pk);
    endtask

    task automatic check_model(string tag);
        check_exp(tag, m_bin, m_step, m_wrap, m_lap, int'(m_st == 1), int'(m_st == 2), m_err);
    endtask

    task automatic add(bit r, bit c, bit v, logic [2:0] g,
                       int bin, int step, int wrap, int lap, int lk, int ft, int err);
        vec_t e;
        e.r = r; e.c = c; e.v = v; e.g = g;
        e.bin = bin; e.step = step; e.wrap = wrap; e.lap = lap;
        e.lk = lk; e.ft = ft; e.err = err;
        tbl.push_back(e);
    endtask

    initial begin
        int b;
        int sel;
        bit r, c, v;

        rst_n = 1'b0; clr = 1'b0; vld = 1'b0; gin = '0;
        m_st = 0; m_bin = 0; m_lap = 0; m_err = 0; m_step = 0; m_wrap = 0;

        // Full lap from reset, hold, reverse, clear, jump with frozen laps, mid-lap reset.
        add(0,0,0,3'b000, 0,0,0,0, 0,0,0);
        add(1,0,1,3'b000, 0,0,0,0, 1,0,0);
        add(1,0,1,3'b001, 1,1,0,0, 1,0,0);
        add(1,0,1,3'b011, 2,1,0,0, 1,0,0);
        add(1,0,1,3'b010, 3,1,0,0, 1,0,0);
        add(1,0,1,3'b110, 4,1,0,0, 1,0,0);
        add(1,0,1,3'b111, 5,1,0,0, 1,0,0);
        add(1,0,1,3'b101, 6,1,0,0, 1,0,0);
        add(1,0,1,3'b100, 7,1,0,0, 1,0,0);
        add(1,0,1,3'b000, 0,1,1,1, 1,0,0);
        add(1,0,0,3'b000, 0,0,0,1, 1,0,0);
        for (int i = 0; i < 4; i++) add(1,0,1,3'b000, 0,0,0,1, 1,0,0);
        add(1,0,1,3'b001, 1,1,0,1, 1,0,0);
        add(1,0,1,3'b011, 2,1,0,1, 1,0,0);
        add(1,0,1,3'b001, 1,0,0,1, 0,1,1);
        add(1,0,1,3'b111, 5,0,0,1, 0,1,1);
        add(1,1,0,3'b000, 5,0,0,0, 0,0,0);
        add(1,0,1,3'b000, 0,0,0,0, 1,0,0);
        add(1,0,1,3'b010, 3,0,0,0, 0,1,2);
        for (int i = 4; i < 12; i++) add(1,0,1,gray(i), i % 8,0,0,0, 0,1,2);
        add(0,0,1,3'b011, 0,0,0,0, 0,0,0);

        @(negedge clk);
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].g);
            check_exp($sformatf("vec%0d", i), tbl[i].bin, tbl[i].step, tbl[i].wrap,
                      tbl[i].lap, tbl[i].lk, tbl[i].ft, tbl[i].err);
        end

        // Two laps, jump into fault, then Clear together with Valid, then relock.
        cyc(0,0,0,3'b000);
        cyc(1,0,1,gray(0));
        for (int i = 1; i <= 16; i++) cyc(1,0,1,gray(i));
        check_exp("two_laps", 0,1,1,2, 1,0,0);
        cyc(1,0,1,gray(3));
        check_exp("jump_lap2", 3,0,0,2, 0,1,2);
        cyc(1,1,1,3'b110);
        check_exp("clear_valid", 3,0,0,0, 0,0,0);
        cyc(1,0,1,3'b110);
        check_exp("relock", 4,0,0,0, 1,0,0);

        // Five laps: narrow counter saturates at 3, wide one reaches 5.
        cyc(0,0,0,3'b000);
        cyc(1,0,1,gray(0));
        for (int i = 1; i <= 40; i++) cyc(1,0,1,gray(i));
        check_exp("five_laps", 0,1,1,5, 1,0,0);
        cyc(1,0,1,gray(1));
        cyc(1,0,1,gray(2));
        cyc(0,0,1,gray(3));
        check_exp("mid_reset", 0,0,0,0, 0,0,0);

        // Randomised stream biased toward legal steps, checked against the model.
        cyc(0,0,0,3'b000);
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom % 64) != 0;
            c   = ($urandom % 32) == 0;
            v   = ($urandom % 4) != 0;
            sel = $urandom % 20;
            if (sel < 12)      b = (m_bin + 1) % 8;
            else if (sel < 15) b = m_bin;
            else if (sel < 17) b = (m_bin + 7) % 8;
            else               b = $urandom % 8;
            cyc(r, c, v, gray(b));
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
